// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Opcode and state encodings shared by the bit-serial sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_LAST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : gate_unit (+ gate_not/and/or/xor/nand/nor primitives)
// Description : Single-bit gate unit, one primitive per function, op-selected.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module gate_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module gate_nor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a | b);
endmodule

module gate_unit
    import gate_pkg::*;
(
    input  logic [2:0] op,
    input  logic       e1,
    input  logic       e2,
    output logic       s
);
    logic w_not, w_and, w_or, w_xor, w_nand, w_nor;

    gate_not  u_not  (.a(e1),         .y(w_not));
    gate_and  u_and  (.a(e1), .b(e2), .y(w_and));
    gate_or   u_or   (.a(e1), .b(e2), .y(w_or));
    gate_xor  u_xor  (.a(e1), .b(e2), .y(w_xor));
    gate_nand u_nand (.a(e1), .b(e2), .y(w_nand));
    gate_nor  u_nor  (.a(e1), .b(e2), .y(w_nor));

    always_comb begin
        s = 1'b0;
        case (op)
            OP_NOT:  s = w_not;
            OP_AND:  s = w_and;
            OP_OR:   s = w_or;
            OP_XOR:  s = w_xor;
            OP_NAND: s = w_nand;
            OP_NOR:  s = w_nor;
            default: s = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/gate_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate_seq
// Description : Bit-serial logic sequencer, LSB first through one gate unit.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_seq
    import gate_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             err
);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_s;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_bit;

    gate_unit u_gate (
        .op (r_op),
        .e1 (r_a[0]),
        .e2 (r_b[0]),
        .s  (w_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_NOT;
            r_s         <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= e1;
                        r_b        <= e2;
                        r_op       <= op;
                        r_cnt      <= '0;
                        r_s        <= '0;
                        r_in_ready <= 1'b0;
                        if (op_legal(op)) begin
                            r_err   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            // Illegal opcode skips the datapath entirely
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_s <= {w_bit, r_s[WIDTH-1:1]};
                    r_a <= r_a >> 1;
                    r_b <= r_b >> 1;
                    if (r_cnt == C_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_gate_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_seq
// Description : Directed plus random checks of gate_seq against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_seq;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             err;

    int errors = 0;
    int checks = 0;

    gate_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .e1        (e1),
        .e2        (e2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_s(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (o)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, wait for result, hold off for 'hold' cycles, hand off.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold);
        logic [WIDTH-1:0] exp_s;
        logic             exp_err;
        int               cyc;
        int               rdy_bad;
        exp_s   = model_s(o, a, b);
        exp_err = (o > 3'd5);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op = o;
        e1 = a;
        e2 = b;
        step();
        in_valid = 1'b0;
        op = 3'($urandom);
        e1 = WIDTH'($urandom);
        e2 = WIDTH'($urandom);
        check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        cyc = 0;
        rdy_bad = 0;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
            if (in_ready) rdy_bad++;
            e1 = WIDTH'($urandom);
        end
        check({tag, "_latency"}, 64'(cyc), exp_err ? 64'd0 : 64'(WIDTH));
        check({tag, "_ready_run"}, 64'(rdy_bad), 64'd0);
        check({tag, "_s"}, 64'(s), 64'(exp_s));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            e1 = WIDTH'($urandom);
            e2 = WIDTH'($urandom);
            op = 3'($urandom);
            step();
            check({tag, "_hold_state"}, {61'd0, out_valid, in_ready, err},
                  {61'd0, 1'b1, 1'b0, exp_err});
            check({tag, "_hold_s"}, 64'(s), 64'(exp_s));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_handoff"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        check({tag, "_s_kept"}, 64'(s), 64'(exp_s));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        e1 = '0;
        e2 = '0;
        step();
        step();
        check("reset", {59'd0, in_ready, out_valid, err, 2'b00}, {59'd0, 1'b1, 1'b0, 1'b0, 2'b00});
        check("reset_s", 64'(s), 64'd0);
        rst = 1'b0;
        step();

        run_op("and",  3'd1, 8'hF0, 8'h3C, 0);
        run_op("not",  3'd0, 8'h5A, 8'hFF, 0);
        run_op("or",   3'd2, 8'h0F, 8'hF0, 0);
        run_op("xor",  3'd3, 8'hAA, 8'hFF, 0);
        run_op("nand", 3'd4, 8'hFF, 8'h0F, 0);
        run_op("nor",  3'd5, 8'h0F, 8'hF0, 0);
        run_op("bp",   3'd3, 8'h96, 8'h3C, 5);
        run_op("ill7", 3'd7, 8'hFF, 8'hFF, 2);
        run_op("ill6", 3'd6, 8'h12, 8'h34, 0);
        run_op("post_ill", 3'd1, 8'hFF, 8'hFF, 0);

        // Reset in the 4th RUN cycle of an AND
        in_valid = 1'b1;
        op = 3'd1;
        e1 = 8'hFF;
        e2 = 8'hFF;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        check("midrst_s", 64'(s), 64'd0);
        run_op("after_rst", 3'd3, 8'h0F, 8'h33, 0);

        // Request coincident with reset is dropped
        rst = 1'b1;
        in_valid = 1'b1;
        op = 3'd7;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_req", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        for (int i = 0; i < WIDTH + 2; i++) step();
        check("rst_req_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

        for (int n = 0; n < 24; n++) begin
            run_op("rand", 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom),
                   int'($urandom_range(0, 3)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
